// File: rtl/inert_intf.sv
// Inertial sensor front end: configures the sensor over the SPI master, then on
// every data-ready interrupt reads pitch rate and Z acceleration and strobes vld.
module inert_intf #(
  parameter int INIT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  typedef enum logic [3:0] {
    INIT_WAIT,
    CFG0,
    CFG1,
    CFG2,
    CFG3,
    WAIT_INT,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH
  } state_t;

  state_t            state_q, state_d;
  logic              issue_q, issue_d;
  logic [INIT_W-1:0] cnt_q, cnt_d;
  logic              int_ff1_q, int_ff1_d;
  logic              int_ff2_q, int_ff2_d;
  logic              wrt_q, wrt_d;
  logic [15:0]       cmd_q, cmd_d;
  logic              vld_q, vld_d;
  logic [15:0]       ptch_q, ptch_d;
  logic [15:0]       az_q, az_d;
  logic [7:0]        pl_q, pl_d;
  logic [7:0]        ph_q, ph_d;
  logic [7:0]        al_q, al_d;

  logic [7:0] rd_byte;
  logic       unused_rd_hi;

  // The sensor returns one register byte per read; the upper half of the word is don't-care.
  assign rd_byte      = rd_data[7:0];
  assign unused_rd_hi = ^rd_data[15:8];

  function automatic logic [15:0] cmd_for(input state_t s);
    case (s)
      CFG0:    cmd_for = 16'h0D02;
      CFG1:    cmd_for = 16'h1053;
      CFG2:    cmd_for = 16'h1150;
      CFG3:    cmd_for = 16'h1460;
      RD_PL:   cmd_for = 16'hA200;
      RD_PH:   cmd_for = 16'hA300;
      RD_AL:   cmd_for = 16'hAC00;
      RD_AH:   cmd_for = 16'hAD00;
      default: cmd_for = 16'h0000;
    endcase
  endfunction

  function automatic state_t next_for(input state_t s);
    case (s)
      CFG0:    next_for = CFG1;
      CFG1:    next_for = CFG2;
      CFG2:    next_for = CFG3;
      RD_PL:   next_for = RD_PH;
      RD_PH:   next_for = RD_AL;
      RD_AL:   next_for = RD_AH;
      default: next_for = WAIT_INT;
    endcase
  endfunction

  // Command states: issue_q high = issue phase (pulse wrt), low = wait for done.
  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    cnt_d     = cnt_q;
    int_ff1_d = INT;
    int_ff2_d = int_ff1_q;
    wrt_d     = 1'b0;
    cmd_d     = cmd_q;
    vld_d     = 1'b0;
    ptch_d    = ptch_q;
    az_d      = az_q;
    pl_d      = pl_q;
    ph_d      = ph_q;
    al_d      = al_q;
    case (state_q)
      INIT_WAIT: begin
        cnt_d = cnt_q + INIT_W'(1);
        if (&cnt_q) begin
          state_d = CFG0;
          issue_d = 1'b1;
        end
      end
      WAIT_INT: begin
        if (int_ff2_q) begin
          state_d = RD_PL;
          issue_d = 1'b1;
        end
      end
      default: begin
        if (issue_q) begin
          wrt_d   = 1'b1;
          cmd_d   = cmd_for(state_q);
          issue_d = 1'b0;
        end else if (done) begin
          state_d = next_for(state_q);
          issue_d = 1'b1;
          // Published words only change once the whole burst has been read.
          case (state_q)
            RD_PL: pl_d = rd_byte;
            RD_PH: ph_d = rd_byte;
            RD_AL: al_d = rd_byte;
            RD_AH: begin
              ptch_d = {ph_q, pl_q};
              az_d   = {rd_byte, al_q};
              vld_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT_WAIT;
      issue_q   <= 1'b0;
      cnt_q     <= '0;
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      wrt_q     <= 1'b0;
      cmd_q     <= 16'h0000;
      vld_q     <= 1'b0;
      ptch_q    <= 16'h0000;
      az_q      <= 16'h0000;
      pl_q      <= 8'h00;
      ph_q      <= 8'h00;
      al_q      <= 8'h00;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      cnt_q     <= cnt_d;
      int_ff1_q <= int_ff1_d;
      int_ff2_q <= int_ff2_d;
      wrt_q     <= wrt_d;
      cmd_q     <= cmd_d;
      vld_q     <= vld_d;
      ptch_q    <= ptch_d;
      az_q      <= az_d;
      pl_q      <= pl_d;
      ph_q      <= ph_d;
      al_q      <= al_d;
    end
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign vld     = vld_q;
  assign ptch_rt = ptch_q;
  assign AZ      = az_q;

endmodule
